pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
//
// PURPOSE
//   Registered program-counter and next-PC unit; the parametrised successor to the
//   combinational branch selector.
//   Owns the PC register and computes fall-through, absolute and signed-relative
//   targets under a selectable condition on the accumulator.
//   Adds a call/return-address stack. Sits between decode (control strobes) and
//   instruction memory (pc_out addresses imem directly).
//
// PARAMETERS
//   D          12  PC / instruction-address width
//   W           8  operand (val) and accumulator width
//   ABS_SHIFT   2  left shift applied to val for absolute targets
//   RAS_DEPTH   4  return-address stack entries (>=1); used only with BRANCH_RAS_EN
//
// PORTS
//   clk             in   1  single clock, all state updates on rising edge
//   reset_n         in   1  synchronous, active-low reset
//   stall           in   1  hold PC and all state this cycle
//   cond            in   2  condition select (branch_pkg::cond_e)
//   absjump_enable  in   1  conditional absolute jump
//   reljump_enable  in   1  conditional relative jump
//   call_enable     in   1  unconditional absolute call (push return address)
//   ret_enable      in   1  unconditional return (pop)
//   val             in   W  jump operand
//   acc             in   W  accumulator value tested by cond
//   pc_out          out  D  current PC (registered)
//   taken           out  1  registered: previous update redirected the PC
//   ras_err         out  1  sticky: RAS overflow or underflow since reset
//
// BEHAVIOUR
//   - Reset (reset_n==0 at clk edge, overrides stall): pc_out=0, taken=0, ras_err=0,
//     RAS pointer=0 (empty). RAS entry contents are don't-care.
//   - stall==1: no state changes; all strobes ignored that cycle.
//   - Otherwise the PC updates once per cycle (one-cycle latency from strobes to pc_out).
//   - Strobe priority when several are asserted: ret > call > abs > rel > fall-through.
//   - Arithmetic, all mod 2^D:
//       fall = pc_out+1
//       abs  = zero_ext(val)<<ABS_SHIFT, truncated to D
//       rel  = pc_out + sign_ext(val)
//   - cond (COND_ALWAYS=0, COND_EQZ=1 acc==0, COND_NEZ=2 acc!=0, COND_NEG=3 acc[W-1])
//     gates abs/rel only; a failed condition selects fall.
//   - call: next=abs target; push fall. ret: next=popped entry.
//   - taken<=1 iff next PC came from abs/rel/call/ret and not fall. A successful jump
//     whose target equals fall still sets taken.
//   - RAS full + call: jump still occurs, push dropped (stack unchanged), ras_err<=1.
//   - RAS empty + ret: next=fall, taken<=0, ras_err<=1.
//   - ras_err clears only on reset. PC wraps 2^D-1 -> 0 silently.
//
// CONFIGURATION
//   BRANCH_RAS_EN defined: RAS present as above.
//   Not defined:
//     - no stack storage; call_enable behaves as an unconditional abs jump (no push).
//     - ret_enable is ignored (treated as no strobe; lower priorities evaluated).
//     - ras_err tied 0.
//     - RAS_DEPTH unused.
//
// STRUCTURE
//   branch_pkg: cond_e enum, COND_* constants, next-PC source enum
//   (SRC_FALL/ABS/REL/CALL/RET) shared with decode.
//   Sub-module ras_stack (push/pop/full/empty, depth RAS_DEPTH, width D), instantiated
//   under `ifdef BRANCH_RAS_EN.
//   Next-PC mux and condition evaluation stay in this module.
//
// TESTING
//   1. reset_n=0 then 1, no strobes, 5 cycles
//      -> pc_out 0,1,2,3,4; taken=0.
//   2. pc=10, reljump, cond=ALWAYS, val=8'hFE
//      -> pc_out=8, taken=1.
//      pc=0, val=8'hFF -> pc_out=4095 (wrap).
//   3. absjump val=8'h05, cond=EQZ:
//      acc=0 -> pc_out=20;
//      acc=3 -> pc_out=pc+1, taken=0.
//      cond=NEG, acc=8'h80 -> taken.
//   4. pc=7, call val=8'h10 -> pc_out=64; later ret -> pc_out=8.
//      Nested calls to depth 4 return in LIFO order.
//   5. 5 calls with RAS_DEPTH=4 -> 5th jumps, ras_err=1.
//      ret on empty stack -> pc=fall, ras_err=1.
//   6. stall=1 with absjump -> pc_out unchanged.
//      reset_n=0 during stall -> pc_out=0.
//      abs+rel together -> abs wins.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - condition and next-PC source encodings shared with decode
package branch_pkg;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_EQZ    = 2'd1,
    COND_NEZ    = 2'd2,
    COND_NEG    = 2'd3
  } cond_e;

  typedef enum logic [2:0] {
    SRC_FALL = 3'd0,
    SRC_ABS  = 3'd1,
    SRC_REL  = 3'd2,
    SRC_CALL = 3'd3,
    SRC_RET  = 3'd4
  } src_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return-address LIFO; push when full and pop when empty are ignored
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_idx;

  assign full    = (ptr == PW'(DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr - 1'b1;
  assign dout    = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  // Entry contents carry no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - registered PC with conditional abs/rel jumps and call/return
// Optional return-address stack enabled by BRANCH_RAS_EN.
module pc_branch_unit
  import branch_pkg::*;
#(
  parameter int D         = 12,
  parameter int W         = 8,
  parameter int ABS_SHIFT = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall,
  input  logic [1:0]   cond,
  input  logic         absjump_enable,
  input  logic         reljump_enable,
  input  logic         call_enable,
  input  logic         ret_enable,
  input  logic [W-1:0] val,
  input  logic [W-1:0] acc,
  output logic [D-1:0] pc_out,
  output logic         taken,
  output logic         ras_err
);

  logic [D-1:0]   fall_tgt;
  logic [D-1:0]   abs_tgt;
  logic [D-1:0]   rel_tgt;
  logic [D+W-1:0] abs_wide;
  logic           cond_ok;
  logic [D-1:0]   next_pc;
  src_e           src;
  logic           push;
  logic           pop;
  logic           err_set;
  logic           ret_req;
  logic           ras_full;
  logic           ras_empty;
  logic [D-1:0]   ras_top;

  assign fall_tgt = pc_out + 1'b1;
  assign abs_wide = {{D{1'b0}}, val} << ABS_SHIFT;
  assign abs_tgt  = abs_wide[D-1:0];
  assign rel_tgt  = pc_out + D'($signed(val));

  always_comb begin
    cond_ok = 1'b1;
    case (cond_e'(cond))
      COND_ALWAYS: cond_ok = 1'b1;
      COND_EQZ:    cond_ok = (acc == '0);
      COND_NEZ:    cond_ok = (acc != '0);
      COND_NEG:    cond_ok = acc[W-1];
      default:     cond_ok = 1'b1;
    endcase
  end

  // Priority ret > call > abs > rel; a ret on an empty stack falls through.
  always_comb begin
    src     = SRC_FALL;
    next_pc = fall_tgt;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (ret_req) begin
      if (ras_empty) begin
        err_set = 1'b1;
      end else begin
        src     = SRC_RET;
        next_pc = ras_top;
        pop     = 1'b1;
      end
    end else if (call_enable) begin
      src     = SRC_CALL;
      next_pc = abs_tgt;
      push    = 1'b1;
      err_set = ras_full;
    end else if (absjump_enable && cond_ok) begin
      src     = SRC_ABS;
      next_pc = abs_tgt;
    end else if (reljump_enable && cond_ok) begin
      src     = SRC_REL;
      next_pc = rel_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_out <= '0;
      taken  <= 1'b0;
    end else if (!stall) begin
      pc_out <= next_pc;
      taken  <= (src != SRC_FALL);
    end
  end

`ifdef BRANCH_RAS_EN
  assign ret_req = ret_enable;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (D)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push && !stall),
    .pop     (pop && !stall),
    .din     (fall_tgt),
    .dout    (ras_top),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ras_err <= 1'b0;
    end else if (!stall && err_set) begin
      ras_err <= 1'b1;
    end
  end
`else
  logic unused_ras;

  assign ret_req    = 1'b0;
  assign ras_full   = 1'b0;
  assign ras_empty  = 1'b1;
  assign ras_top    = '0;
  assign ras_err    = 1'b0;
  assign unused_ras = ^{push, pop, err_set, ret_enable, (RAS_DEPTH != 0)};
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - scoreboard bench for pc_branch_unit, directed vectors
module tb_pc_branch_unit;

`ifdef BRANCH_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  localparam logic [1:0] ALW = 2'd0;
  localparam logic [1:0] EQZ = 2'd1;
  localparam logic [1:0] NEZ = 2'd2;
  localparam logic [1:0] NEG = 2'd3;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic [1:0]  cond;
  logic        absjump_enable;
  logic        reljump_enable;
  logic        call_enable;
  logic        ret_enable;
  logic [7:0]  val;
  logic [7:0]  acc;
  logic [11:0] pc_out;
  logic        taken;
  logic        ras_err;

  typedef struct {
    string name;
    int    pc;
    bit    t;
    bit    e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pc_branch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .cond           (cond),
    .absjump_enable (absjump_enable),
    .reljump_enable (reljump_enable),
    .call_enable    (call_enable),
    .ret_enable     (ret_enable),
    .val            (val),
    .acc            (acc),
    .pc_out         (pc_out),
    .taken          (taken),
    .ras_err        (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are registered, so one expectation is due after every edge.
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (pc_out !== 12'(x.pc)) begin
        n_bad++;
        $display("FAIL %s pc_out: got %0d expected %0d", x.name, pc_out, x.pc);
      end
      n_cmp++;
      if (taken !== x.t) begin
        n_bad++;
        $display("FAIL %s taken: got %b expected %b", x.name, taken, x.t);
      end
      n_cmp++;
      if (ras_err !== x.e) begin
        n_bad++;
        $display("FAIL %s ras_err: got %b expected %b", x.name, ras_err, x.e);
      end
    end
  end

  task automatic step(input string name, input bit rn, input bit st, input logic [1:0] c,
                      input bit ab, input bit rl, input bit ca, input bit rt,
                      input logic [7:0] v, input logic [7:0] a,
                      input int epc, input bit et, input bit ee);
    exp_t x;
    reset_n        = rn;
    stall          = st;
    cond           = c;
    absjump_enable = ab;
    reljump_enable = rl;
    call_enable    = ca;
    ret_enable     = rt;
    val            = v;
    acc            = a;
    x.name = name;
    x.pc   = epc;
    x.t    = et;
    x.e    = ee;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input int epc, input bit ee);
    step(name, 1, 0, ALW, 0, 0, 0, 0, 8'h00, 8'h00, epc, 0, ee);
  endtask

  initial begin
    bit e;
    step("reset", 0, 0, ALW, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 10; i++) idle("fall", i, 0);

    step("rel_back",  1, 0, ALW, 0, 1, 0, 0, 8'hFE, 8'h00, 8, 1, 0);
    step("abs_zero",  1, 0, ALW, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    step("rel_wrap",  1, 0, ALW, 0, 1, 0, 0, 8'hFF, 8'h00, 4095, 1, 0);
    idle("pc_wrap", 0, 0);

    step("abs_eqz_t", 1, 0, EQZ, 1, 0, 0, 0, 8'h05, 8'h00, 20, 1, 0);
    step("abs_eqz_f", 1, 0, EQZ, 1, 0, 0, 0, 8'h05, 8'h03, 21, 0, 0);
    step("abs_neg_t", 1, 0, NEG, 1, 0, 0, 0, 8'h05, 8'h80, 20, 1, 0);
    step("rel_nez_t", 1, 0, NEZ, 0, 1, 0, 0, 8'h02, 8'h03, 22, 1, 0);
    step("rel_nez_f", 1, 0, NEZ, 0, 1, 0, 0, 8'h02, 8'h00, 23, 0, 0);
    step("abs_neg_f", 1, 0, NEG, 1, 0, 0, 0, 8'h05, 8'h7F, 24, 0, 0);
    step("rel_eq_fall", 1, 0, ALW, 0, 1, 0, 0, 8'h01, 8'h00, 25, 1, 0);

    step("abs_4", 1, 0, ALW, 1, 0, 0, 0, 8'h01, 8'h00, 4, 1, 0);
    idle("fall", 5, 0);
    idle("fall", 6, 0);
    idle("fall", 7, 0);
    step("call_64", 1, 0, ALW, 0, 0, 1, 0, 8'h10, 8'h00, 64, 1, 0);
    idle("fall", 65, 0);
    step("ret_8", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, RAS ? 8 : 66, RAS, 0);

    step("abs_zero", 1, 0, ALW, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    step("call_d1", 1, 0, ALW, 0, 0, 1, 0, 8'h01, 8'h00, 4, 1, 0);
    step("call_d2", 1, 0, ALW, 0, 0, 1, 0, 8'h02, 8'h00, 8, 1, 0);
    step("call_d3", 1, 0, ALW, 0, 0, 1, 0, 8'h03, 8'h00, 12, 1, 0);
    step("call_d4", 1, 0, ALW, 0, 0, 1, 0, 8'h04, 8'h00, 16, 1, 0);
    e = RAS;
    step("call_ovf", 1, 0, ALW, 0, 0, 1, 0, 8'h05, 8'h00, 20, 1, e);
    step("ret_l4", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, RAS ? 13 : 21, RAS, e);
    step("ret_l3", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, RAS ? 9 : 22, RAS, e);
    step("ret_l2", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, RAS ? 5 : 23, RAS, e);
    step("ret_l1", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, RAS ? 1 : 24, RAS, e);

    step("reset2", 0, 0, ALW, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    step("ret_empty", 1, 0, ALW, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0, e);
    idle("err_sticky", 2, e);

    step("abs_12", 1, 0, ALW, 1, 0, 0, 0, 8'h03, 8'h00, 12, 1, e);
    step("stall_hold", 1, 1, ALW, 1, 0, 0, 0, 8'h09, 8'h00, 12, 1, e);
    step("stall_reset", 0, 1, ALW, 1, 0, 0, 0, 8'h09, 8'h00, 0, 0, 0);
    step("abs_over_rel", 1, 0, ALW, 1, 1, 0, 0, 8'h02, 8'h00, 8, 1, 0);
    step("ret_over_call", 1, 0, ALW, 0, 0, 1, 1, 8'h04, 8'h00, RAS ? 9 : 16, !RAS, e);

    step("idle_end", 1, 0, ALW, 0, 0, 0, 0, 8'h00, 8'h00, RAS ? 10 : 17, 0, e);
    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
